// File: rtl/range_finder_ctrl.sv
// rtl/range_finder_ctrl.sv - frame min/max/range/count accumulator with result handshake
module range_finder_ctrl #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [DATA_W-1:0] r_min,
  output logic [DATA_W-1:0] r_max,
  output logic [DATA_W-1:0] r_range,
  output logic [CNT_W-1:0]  r_count,
  output logic              r_sat,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    RESULT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state_q, state_d;

  // Running accumulators for the frame in progress
  logic [DATA_W-1:0] min_q, min_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sat_q, sat_d;

  // Published result, separate so it stays put while the next frame accumulates
  logic [DATA_W-1:0] r_min_q, r_min_d;
  logic [DATA_W-1:0] r_max_q, r_max_d;
  logic [DATA_W-1:0] r_range_q, r_range_d;
  logic [CNT_W-1:0]  r_count_q, r_count_d;
  logic              r_sat_q, r_sat_d;

  logic              accept;
  logic [DATA_W-1:0] min_nx, max_nx;
  logic [CNT_W-1:0]  cnt_nx;
  logic              sat_nx;

  // Accumulator values that would result from accepting the current beat
  always_comb begin
    accept = (state_q == ACCUM) && s_valid && !abort;
    min_nx = (s_data < min_q) ? s_data : min_q;
    max_nx = (s_data > max_q) ? s_data : max_q;
    cnt_nx = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    sat_nx = sat_q | (cnt_q == CNT_MAX);
  end

  // Next-state and datapath update; abort overrides everything else
  always_comb begin
    state_d   = state_q;
    min_d     = min_q;
    max_d     = max_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    r_min_d   = r_min_q;
    r_max_d   = r_max_q;
    r_range_d = r_range_q;
    r_count_d = r_count_q;
    r_sat_d   = r_sat_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = ACCUM;
            min_d   = '1;
            max_d   = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
          end
        end
        ACCUM: begin
          if (accept) begin
            min_d = min_nx;
            max_d = max_nx;
            cnt_d = cnt_nx;
            sat_d = sat_nx;
            if (s_last) begin
              state_d   = RESULT;
              r_min_d   = min_nx;
              r_max_d   = max_nx;
              r_range_d = max_nx - min_nx;
              r_count_d = cnt_nx;
              r_sat_d   = sat_nx;
            end
          end
        end
        RESULT: begin
          if (r_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and data registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      min_q     <= '0;
      max_q     <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      r_min_q   <= '0;
      r_max_q   <= '0;
      r_range_q <= '0;
      r_count_q <= '0;
      r_sat_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      max_q     <= max_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      r_min_q   <= r_min_d;
      r_max_q   <= r_max_d;
      r_range_q <= r_range_d;
      r_count_q <= r_count_d;
      r_sat_q   <= r_sat_d;
    end
  end

  assign s_ready = (state_q == ACCUM);
  assign r_valid = (state_q == RESULT);
  assign busy    = (state_q != IDLE);
  assign r_min   = r_min_q;
  assign r_max   = r_max_q;
  assign r_range = r_range_q;
  assign r_count = r_count_q;
  assign r_sat   = r_sat_q;

endmodule

// File: tb/tb_range_finder_ctrl.sv
// tb/tb_range_finder_ctrl.sv - self-checking bench for range_finder_ctrl
module tb_range_finder_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = 8'h00;
  logic       s_last = 1'b0;
  logic       r_valid;
  logic       r_ready = 1'b0;
  logic [7:0] r_min, r_max, r_range;
  logic [7:0] r_count;
  logic       r_sat;
  logic       busy;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] acc[$];
  logic [7:0] e_min, e_max, e_range, e_count;
  logic       e_sat;

  range_finder_ctrl #(.DATA_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .r_valid(r_valid), .r_ready(r_ready),
    .r_min(r_min), .r_max(r_max), .r_range(r_range),
    .r_count(r_count), .r_sat(r_sat), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: statistics of the accepted-sample list, plain arithmetic
  task automatic compute_exp();
    int mn, mx, n;
    mn = 255; mx = 0; n = acc.size();
    foreach (acc[i]) begin
      if (acc[i] < mn) mn = acc[i];
      if (acc[i] > mx) mx = acc[i];
    end
    e_min   = 8'(mn);
    e_max   = 8'(mx);
    e_range = 8'(mx - mn);
    e_count = (n > 255) ? 8'd255 : 8'(n);
    e_sat   = (n > 255);
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    acc.delete();
    chk({tag, "_start_busy"}, busy, 1);
    chk({tag, "_start_ready"}, s_ready, 1);
  endtask

  task automatic beat(input logic [7:0] d, input logic last);
    s_valid = 1'b1; s_data = d; s_last = last;
    step();
    acc.push_back(d);
    s_valid = 1'b0; s_last = 1'b0; s_data = 8'($urandom);
  endtask

  task automatic gap();
    s_valid = 1'b0; s_data = 8'($urandom); s_last = 1'($urandom);
    step();
    s_last = 1'b0;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_min"}, r_min, e_min);
    chk({tag, "_max"}, r_max, e_max);
    chk({tag, "_range"}, r_range, e_range);
    chk({tag, "_count"}, r_count, e_count);
    chk({tag, "_sat"}, r_sat, e_sat);
  endtask

  task automatic check_result(input string tag);
    chk({tag, "_rvalid"}, r_valid, 1);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_sready"}, s_ready, 0);
    check_outs(tag);
  endtask

  task automatic finish_result(input string tag, input int hold);
    for (int k = 0; k < hold; k++) begin
      if (k % 2 == 0) start = 1'b1;
      step();
      start = 1'b0;
      check_result({tag, "_hold"});
    end
    r_ready = 1'b1;
    step();
    r_ready = 1'b0;
    chk({tag, "_done_rvalid"}, r_valid, 0);
    chk({tag, "_done_busy"}, busy, 0);
    check_outs({tag, "_kept"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1;
    e_min = 0; e_max = 0; e_range = 0; e_count = 0; e_sat = 0;
    chk("rst_busy", busy, 0);
    chk("rst_sready", s_ready, 0);
    chk("rst_rvalid", r_valid, 0);
    check_outs("rst");
    step();
    rst = 1'b0;
    step();

    // Basic frame
    do_start("frame");
    beat(8'h40, 0); beat(8'h10, 0); beat(8'hC8, 1);
    compute_exp();
    chk("frame_ref_range", e_range, 8'hB8);
    check_result("frame");
    finish_result("frame", 0);

    // Backpressure: gaps in s_valid, result held for 5 cycles with start pokes
    do_start("bp");
    gap(); beat(8'h33, 0); gap(); gap(); beat(8'h90, 0); gap(); beat(8'h21, 1);
    compute_exp();
    check_result("bp");
    finish_result("bp", 5);

    // Saturation
    do_start("sat");
    for (int i = 0; i < 300; i++) beat(8'h55, (i == 299));
    compute_exp();
    check_result("sat");
    finish_result("sat", 1);

    // Abort mid-frame, with a concurrent valid beat that must not be taken
    do_start("abt");
    beat(8'h01, 0); beat(8'hF0, 0);
    abort = 1'b1; s_valid = 1'b1; s_data = 8'h02; s_last = 1'b1;
    step();
    abort = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    chk("abt_busy", busy, 0);
    chk("abt_rvalid", r_valid, 0);
    check_outs("abt_kept");
    do_start("abt2");
    beat(8'h07, 1);
    compute_exp();
    check_result("abt2");

    // Abort in RESULT beats start and r_ready; outputs retained
    abort = 1'b1; start = 1'b1; r_ready = 1'b1;
    step();
    abort = 1'b0; start = 1'b0; r_ready = 1'b0;
    chk("abtres_rvalid", r_valid, 0);
    chk("abtres_busy", busy, 0);
    check_outs("abtres_kept");

    // Boundaries
    do_start("bnd1");
    beat(8'h00, 0); beat(8'hFF, 1);
    compute_exp();
    check_result("bnd1");
    finish_result("bnd1", 0);
    do_start("bnd2");
    beat(8'hFF, 1);
    compute_exp();
    check_result("bnd2");
    finish_result("bnd2", 0);

    // Random frames with start ignored during ACCUM
    for (int f = 0; f < 6; f++) begin
      int len;
      len = $urandom_range(1, 12);
      do_start("rnd");
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          start = 1'($urandom);
          gap();
          start = 1'b0;
        end
        beat(8'($urandom), (i == len - 1));
      end
      compute_exp();
      check_result("rnd");
      finish_result("rnd", $urandom_range(0, 3));
    end

    // Asynchronous reset mid-frame
    do_start("ar");
    beat(8'h80, 0);
    #2 rst = 1'b1;
    #1;
    e_min = 0; e_max = 0; e_range = 0; e_count = 0; e_sat = 0;
    chk("ar_busy", busy, 0);
    chk("ar_sready", s_ready, 0);
    chk("ar_rvalid", r_valid, 0);
    check_outs("ar");
    #1 rst = 1'b0;
    s_valid = 1'b1; s_data = 8'h11; s_last = 1'b1;
    step();
    s_valid = 1'b0; s_last = 1'b0;
    chk("ar_nostart_busy", busy, 0);
    chk("ar_nostart_rvalid", r_valid, 0);
    do_start("ar2");
    beat(8'h3C, 0); beat(8'h2A, 1);
    compute_exp();
    check_result("ar2");
    finish_result("ar2", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/range_finder_ctrl.md
RANGE_FINDER_CTRL -- requirements
Module: range_finder_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8: sample and result width in bits.
REQ-002 SHALL have parameter CNT_W, default 8: sample-counter width in bits.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port start, input, 1: one-cycle frame-start command.
REQ-006 SHALL have port abort, input, 1: one-cycle frame cancel.
REQ-007 SHALL have port s_valid, input, 1: sample beat valid.
REQ-008 SHALL have port s_ready, output, 1: controller accepts a sample.
REQ-009 SHALL have port s_data, input, DATA_W: unsigned sample.
REQ-010 SHALL have port s_last, input, 1: marks the final beat of the frame.
REQ-011 SHALL have port r_valid, output, 1: result valid.
REQ-012 SHALL have port r_ready, input, 1: consumer takes the result.
REQ-013 SHALL have port r_min, output, DATA_W: frame minimum.
REQ-014 SHALL have port r_max, output, DATA_W: frame maximum.
REQ-015 SHALL have port r_range, output, DATA_W: r_max minus r_min.
REQ-016 SHALL have port r_count, output, CNT_W: number of accepted beats, saturating.
REQ-017 SHALL have port r_sat, output, 1: r_count saturated during the frame.
REQ-018 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-019 SHALL implement a three-state FSM: IDLE, ACCUM, RESULT.
REQ-020 In IDLE, start=1 SHALL move to ACCUM next cycle and load min=all-ones, max=0, count=0, sat=0.
REQ-021 In ACCUM, s_ready SHALL be 1; in IDLE and RESULT it SHALL be 0. s_ready is a registered state decode, not combinational on s_valid.
REQ-022 A beat SHALL be accepted only when s_valid and s_ready are both 1 in the same cycle.
REQ-023 On accept: min=min(min,s_data), max=max(max,s_data), unsigned compare; count+1.
REQ-024 count SHALL saturate at 2^CNT_W-1; an accept at saturation SHALL set sat=1 and leave count unchanged.
REQ-025 An accepted beat with s_last=1 SHALL go to RESULT next cycle, with results including that beat.
REQ-026 r_range SHALL be registered on entry to RESULT as max-min, DATA_W bits; it never underflows because min<=max once any beat is accepted.
REQ-027 In RESULT, r_valid SHALL be 1 and r_min/r_max/r_range/r_count/r_sat SHALL hold stable until the handshake completes.
REQ-028 In RESULT, r_ready=1 SHALL return to IDLE next cycle with r_valid=0; the result outputs SHALL keep their last values in IDLE.
REQ-029 start SHALL be ignored in ACCUM and RESULT.
REQ-030 s_valid with s_ready=0 SHALL be ignored; the controller never accepts or drops a beat outside ACCUM.
REQ-031 abort=1 in any state SHALL force IDLE next cycle, clear r_valid and discard the frame; abort takes priority over start, beat accept and r_ready.
REQ-032 Latency SHALL be one cycle from the last-beat accept to r_valid=1; throughput SHALL be one beat per cycle in ACCUM.
REQ-033 A single-beat frame SHALL give r_min=r_max=sample, r_range=0, r_count=1.

Reset
REQ-034 rst=1 SHALL immediately, without waiting for clk, force IDLE with s_ready=0, r_valid=0, busy=0, r_min=0, r_max=0, r_range=0, r_count=0, r_sat=0.
REQ-035 Reset asserted mid-frame or mid-result SHALL discard all frame state; the first post-reset frame SHALL need a fresh start.

Verification
REQ-036 Frame test: start, beats 0x40, 0x10, 0xC8(last), r_ready=1 -> r_valid one cycle after last; min=0x10, max=0xC8, range=0xB8, count=3, sat=0.
REQ-037 Backpressure test: s_valid toggled with gaps and r_ready held low 5 cycles -> only valid beats counted; outputs stable while r_valid=1 and r_ready=0.
REQ-038 Saturation test, CNT_W=8: 300 beats of 0x55, the last one flagged -> count=255, sat=1, min=max=0x55, range=0.
REQ-039 Abort test: abort after 2 beats, then start and frame {0x07(last)} -> previous beats excluded; min=max=0x07, count=1.
REQ-040 Reset test: rst pulsed asynchronously between clock edges during ACCUM -> outputs reach reset values before the next edge; start during ACCUM or RESULT has no effect.
REQ-041 Boundary test: frame {0x00, 0xFF(last)} -> range=0xFF; frame {0xFF(last)} -> min=max=0xFF, range=0.
